lsu_multi: RTL and testbench
============================

Name: lsu_multi

Overview:
- Initiator-side sequencer that drives the data-cache access port (address, write data, uop) and consumes its registered read data.
- Accepts one block-transfer request from execute (load-multiple or store-multiple, base address, 16-bit register list).
- Walks the list lowest register first, issuing one cache access per cycle, reading the register file for stores and emitting writebacks for loads.
- Optionally returns the updated base.

Parameters:
- STR_UOP, 5'b01001, uop code driven for a cache store.
- LDR_UOP, 5'b01010, uop code driven for a cache load.
- NOP_UOP, 5'b00000, uop driven when no access is issued.
- ADDR_STEP, 1, address increment per transferred word (cache is word-indexed).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_is_load  in  1  1 = load-multiple, 0 = store-multiple.
- req_base  in  32  start address.
- req_reglist  in  16  bit i set = transfer register i.
- req_wback  in  1  return updated base on completion.
- dc_addr  out  32  cache address.
- dc_data_in  out  32  cache write data.
- dc_uop  out  5  cache uop.
- dc_data_out  in  32  cache read data, valid the cycle after an LDR_UOP issue.
- rf_raddr  out  4  register-file read index (combinational read).
- rf_rdata  in  32  register-file read data.
- wb_valid  out  1  load writeback strobe.
- wb_reg  out  4  load destination register.
- wb_data  out  32  load data.
- base_wb_valid  out  1  updated-base strobe.
- base_wb_data  out  32  req_base + ADDR_STEP*popcount(req_reglist).
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values:
  - req_ready=0 during reset, 1 the cycle after reset deasserts.
  - dc_uop=NOP_UOP; dc_addr, dc_data_in, wb_data, base_wb_data = 0.
  - wb_valid, base_wb_valid, done = 0.
  - rf_raddr=0.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - req_ready=1 and dc_uop=NOP_UOP.
  - On req_valid, latch all request fields and the remaining-list mask. The request is accepted at that edge.
  - Non-empty list → ISSUE; empty list → FINISH (no cache access).
- ISSUE, each cycle:
  - Current register = lowest set bit of the remaining mask.
  - dc_addr = latched base + ADDR_STEP*(index of this transfer).
  - dc_uop = LDR_UOP or STR_UOP.
  - For stores: rf_raddr = current register and dc_data_in = rf_rdata, the same cycle.
  - At the edge, clear that bit. When the last bit clears: loads → DRAIN, stores → FINISH.
- Load pipeline:
  - A load issued in cycle N is written back in cycle N+1: wb_valid=1, wb_reg=its register, wb_data=dc_data_out sampled in N+1.
  - Issue and writeback overlap, so an n-register load takes n issue cycles plus 1 drain cycle.
- DRAIN:
  - dc_uop=NOP_UOP.
  - Final writeback is emitted.
  - → FINISH.
- FINISH:
  - done=1 for exactly one cycle.
  - base_wb_valid=1 with base_wb_data if req_wback, else 0.
  - dc_uop=NOP_UOP.
  - → IDLE.
- Outputs other than the dc_* access bus are registered.
- dc_* is driven from state registers only, with no combinational path from req_*.
- req_ready=0 in every state except IDLE, so a new request is accepted no earlier than the cycle after done.
- Address arithmetic is 32-bit modulo: 0xFFFFFFFF + 1 wraps to 0. base_wb_data wraps the same way.
- Stores never assert wb_valid.
- Register 15 is handled like any other register.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE.
  - dc_uop=NOP_UOP and all strobes 0 from the reset edge.
  - No writeback of an in-flight load.
- Latency:
  - Store of n registers: done n+1 cycles after acceptance.
  - Load of n registers: done n+2 cycles after acceptance.
  - Empty list: done 1 cycle after acceptance.

Test Plan:
- Reset then idle → req_ready=1, dc_uop=NOP_UOP, no strobes for 10 cycles.
- Store: reglist=0x0005, base=4, R0=0xAAAA0000, R2=0x2222 → STR at addr 4 (0xAAAA0000) then addr 5 (0x2222); done 3 cycles after acceptance; no wb_valid.
- Load: reglist=0x8003 from base 4 after the store above (cache word 6 = 0x66) → wb (R0,0xAAAA0000), (R1,0x2222), (R15,0x66) on consecutive cycles; done next cycle.
- Writeback and empty list: reglist=0x00F0, base=0xFFFFFFFE, req_wback=1 → addresses FFFFFFFE, FFFFFFFF, 0, 1; base_wb_data=2 with done. Then reglist=0 → done 1 cycle after acceptance, no dc access, base_wb_data=base.
- Back-to-back: req_valid held high across two requests → second accepted only in the cycle after the first done; req_ready=0 throughout the first.
- Reset asserted on the second issue cycle of a 4-register load → dc_uop=NOP_UOP and no wb_valid from the reset edge; req_ready=1 the cycle after reset deasserts; a fresh request then completes correctly.

Source files
------------

// File: rtl/lsu_multi.sv
// ============================================================================
// lsu_multi : load/store-multiple sequencer driving a word-indexed data cache
// Revision  : 1.0
// ============================================================================
`default_nettype none

module lsu_multi #(
   parameter logic [4:0]  STR_UOP   = 5'b01001,
   parameter logic [4:0]  LDR_UOP   = 5'b01010,
   parameter logic [4:0]  NOP_UOP   = 5'b00000,
   parameter logic [31:0] ADDR_STEP = 32'd1
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_is_load_i,
   input  logic [31:0] req_base_i,
   input  logic [15:0] req_reglist_i,
   input  logic        req_wback_i,
   output logic [31:0] dc_addr_o,
   output logic [31:0] dc_data_in_o,
   output logic [4:0]  dc_uop_o,
   input  logic [31:0] dc_data_out_i,
   output logic [3:0]  rf_raddr_o,
   input  logic [31:0] rf_rdata_i,
   output logic        wb_valid_o,
   output logic [3:0]  wb_reg_o,
   output logic [31:0] wb_data_o,
   output logic        base_wb_valid_o,
   output logic [31:0] base_wb_data_o,
   output logic        done_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        ready_q;
   logic        is_load_q;
   logic        wback_q;
   logic [31:0] addr_q;
   logic [15:0] mask_q;
   logic        wb_valid_q;
   logic [3:0]  wb_reg_q;

   logic [3:0]  cur_reg;
   logic [15:0] mask_clr;
   logic        accept;

   // Lowest set bit of the remaining mask is the register transferred this cycle.
   always_comb begin
      cur_reg = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (mask_q[i]) cur_reg = 4'(i);
      end
   end

   assign mask_clr = mask_q & ~(16'd1 << cur_reg);
   assign accept   = (state_q == S_IDLE) && ready_q && req_valid_i;

   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = (req_reglist_i == 16'd0) ? S_FINISH : S_ISSUE;
         S_ISSUE:  if (mask_clr == 16'd0) state_d = is_load_q ? S_DRAIN : S_FINISH;
         S_DRAIN:  state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // addr_q walks from the base one step per issue, so at FINISH it already
   // holds the updated base.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ready_q    <= 1'b0;
         is_load_q  <= 1'b0;
         wback_q    <= 1'b0;
         addr_q     <= 32'd0;
         mask_q     <= 16'd0;
         wb_valid_q <= 1'b0;
         wb_reg_q   <= 4'd0;
      end else begin
         ready_q    <= (state_d == S_IDLE);
         wb_valid_q <= (state_q == S_ISSUE) && is_load_q;
         if (state_q == S_ISSUE) wb_reg_q <= cur_reg;
         if (accept) begin
            is_load_q <= req_is_load_i;
            wback_q   <= req_wback_i;
            addr_q    <= req_base_i;
            mask_q    <= req_reglist_i;
         end else if (state_q == S_ISSUE) begin
            mask_q <= mask_clr;
            addr_q <= addr_q + ADDR_STEP;
         end
      end
   end

   always_comb begin
      dc_uop_o        = NOP_UOP;
      dc_addr_o       = 32'd0;
      dc_data_in_o    = 32'd0;
      done_o          = 1'b0;
      base_wb_valid_o = 1'b0;
      base_wb_data_o  = 32'd0;
      case (state_q)
         S_ISSUE: begin
            dc_addr_o = addr_q;
            if (is_load_q) begin
               dc_uop_o = LDR_UOP;
            end else begin
               dc_uop_o     = STR_UOP;
               dc_data_in_o = rf_rdata_i;
            end
         end
         S_FINISH: begin
            done_o = 1'b1;
            if (wback_q) begin
               base_wb_valid_o = 1'b1;
               base_wb_data_o  = addr_q;
            end
         end
         default: ;
      endcase
   end

   // Cache read data arrives registered, so it is forwarded in the writeback cycle.
   assign rf_raddr_o  = cur_reg;
   assign req_ready_o = ready_q;
   assign wb_valid_o  = wb_valid_q;
   assign wb_reg_o    = wb_reg_q;
   assign wb_data_o   = wb_valid_q ? dc_data_out_i : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_multi.sv
// ============================================================================
// tb_lsu_multi : directed self-checking bench for lsu_multi
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_multi;

   localparam logic [4:0] STR = 5'b01001;
   localparam logic [4:0] LDR = 5'b01010;
   localparam logic [4:0] NOP = 5'b00000;

   logic        clock, reset;
   logic        req_valid, req_ready, req_is_load, req_wback;
   logic [31:0] req_base;
   logic [15:0] req_reglist;
   logic [31:0] dc_addr, dc_data_in, dc_data_out;
   logic [4:0]  dc_uop;
   logic [3:0]  rf_raddr, wb_reg;
   logic [31:0] rf_rdata, wb_data, base_wb_data;
   logic        wb_valid, base_wb_valid, done;

   logic [31:0] rf  [16];
   logic [31:0] mem [32];

   int checks = 0;
   int errors = 0;

   lsu_multi dut (
      .clock_i(clock), .reset_i(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_is_load_i(req_is_load), .req_base_i(req_base),
      .req_reglist_i(req_reglist), .req_wback_i(req_wback),
      .dc_addr_o(dc_addr), .dc_data_in_o(dc_data_in), .dc_uop_o(dc_uop),
      .dc_data_out_i(dc_data_out),
      .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
      .wb_valid_o(wb_valid), .wb_reg_o(wb_reg), .wb_data_o(wb_data),
      .base_wb_valid_o(base_wb_valid), .base_wb_data_o(base_wb_data),
      .done_o(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign rf_rdata = rf[rf_raddr];

   // Word-indexed cache model with registered read data (low 5 address bits).
   initial dc_data_out = 32'd0;
   always @(posedge clock) begin
      if (dc_uop == STR) mem[dc_addr[4:0]] = dc_data_in;
      else if (dc_uop == LDR) dc_data_out <= mem[dc_addr[4:0]];
   end

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic send(input logic ld, input logic [31:0] base, input logic [15:0] list, input logic wb);
      req_valid = 1'b1; req_is_load = ld; req_base = base; req_reglist = list; req_wback = wb;
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) begin
         cyc();
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
         checks++; if (dc_uop !== NOP) begin errors++; $display("FAIL rst_uop got %h exp %h", dc_uop, NOP); end
         checks++; if ({wb_valid, base_wb_valid, done} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b exp 000", {wb_valid, base_wb_valid, done}); end
         checks++; if ({dc_addr, dc_data_in, wb_data, base_wb_data} !== 128'd0) begin errors++; $display("FAIL rst_data got %h exp 0", {dc_addr, dc_data_in, wb_data, base_wb_data}); end
         checks++; if (rf_raddr !== 4'd0) begin errors++; $display("FAIL rst_raddr got %h exp 0", rf_raddr); end
      end
      reset = 1'b0;
      cyc();
      for (int i = 0; i < 10; i++) begin
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready[%0d] got %b exp 1", i, req_ready); end
         checks++; if (dc_uop !== NOP) begin errors++; $display("FAIL idle_uop[%0d] got %h exp %h", i, dc_uop, NOP); end
         checks++; if ({wb_valid, base_wb_valid, done} !== 3'b000) begin errors++; $display("FAIL idle_strobes[%0d] got %b exp 000", i, {wb_valid, base_wb_valid, done}); end
         cyc();
      end
   endtask

   task automatic test_store();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL st_ready0 got %b exp 1", req_ready); end
      send(1'b0, 32'd4, 16'h0005, 1'b0);
      checks++; if (dc_uop !== STR) begin errors++; $display("FAIL st_c1_uop got %h exp %h", dc_uop, STR); end
      checks++; if (dc_addr !== 32'd4) begin errors++; $display("FAIL st_c1_addr got %h exp 4", dc_addr); end
      checks++; if (rf_raddr !== 4'd0) begin errors++; $display("FAIL st_c1_raddr got %h exp 0", rf_raddr); end
      checks++; if (dc_data_in !== 32'hAAAA0000) begin errors++; $display("FAIL st_c1_data got %h exp AAAA0000", dc_data_in); end
      checks++; if ({req_ready, wb_valid} !== 2'b00) begin errors++; $display("FAIL st_c1_rdy_wb got %b exp 00", {req_ready, wb_valid}); end
      cyc();
      checks++; if (dc_uop !== STR) begin errors++; $display("FAIL st_c2_uop got %h exp %h", dc_uop, STR); end
      checks++; if (dc_addr !== 32'd5) begin errors++; $display("FAIL st_c2_addr got %h exp 5", dc_addr); end
      checks++; if (rf_raddr !== 4'd2) begin errors++; $display("FAIL st_c2_raddr got %h exp 2", rf_raddr); end
      checks++; if (dc_data_in !== 32'h00002222) begin errors++; $display("FAIL st_c2_data got %h exp 00002222", dc_data_in); end
      checks++; if ({wb_valid, done} !== 2'b00) begin errors++; $display("FAIL st_c2_wb_done got %b exp 00", {wb_valid, done}); end
      cyc();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL st_c3_done got %b exp 1", done); end
      checks++; if (dc_uop !== NOP) begin errors++; $display("FAIL st_c3_uop got %h exp %h", dc_uop, NOP); end
      checks++; if ({wb_valid, base_wb_valid, req_ready} !== 3'b000) begin errors++; $display("FAIL st_c3_strobes got %b exp 000", {wb_valid, base_wb_valid, req_ready}); end
      cyc();
      checks++; if ({done, req_ready} !== 2'b01) begin errors++; $display("FAIL st_c4_done_rdy got %b exp 01", {done, req_ready}); end
   endtask

   task automatic test_load();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ld_ready0 got %b exp 1", req_ready); end
      send(1'b1, 32'd4, 16'h8003, 1'b0);
      checks++; if ({dc_uop, dc_addr} !== {LDR, 32'd4}) begin errors++; $display("FAIL ld_c1_issue got %h exp %h", {dc_uop, dc_addr}, {LDR, 32'd4}); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_c1_wb got %b exp 0", wb_valid); end
      cyc();
      checks++; if ({dc_uop, dc_addr} !== {LDR, 32'd5}) begin errors++; $display("FAIL ld_c2_issue got %h exp %h", {dc_uop, dc_addr}, {LDR, 32'd5}); end
      checks++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 4'd0, 32'hAAAA0000}) begin errors++; $display("FAIL ld_c2_wb got %h exp %h", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd0, 32'hAAAA0000}); end
      cyc();
      checks++; if ({dc_uop, dc_addr} !== {LDR, 32'd6}) begin errors++; $display("FAIL ld_c3_issue got %h exp %h", {dc_uop, dc_addr}, {LDR, 32'd6}); end
      checks++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 4'd1, 32'h00002222}) begin errors++; $display("FAIL ld_c3_wb got %h exp %h", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd1, 32'h00002222}); end
      cyc();
      checks++; if (dc_uop !== NOP) begin errors++; $display("FAIL ld_c4_uop got %h exp %h", dc_uop, NOP); end
      checks++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 4'd15, 32'h00000066}) begin errors++; $display("FAIL ld_c4_wb got %h exp %h", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd15, 32'h00000066}); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL ld_c4_done got %b exp 0", done); end
      cyc();
      checks++; if ({done, wb_valid} !== 2'b10) begin errors++; $display("FAIL ld_c5_done_wb got %b exp 10", {done, wb_valid}); end
      cyc();
   endtask

   task automatic test_wback_empty();
      logic [31:0] exp_a;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wbk_ready0 got %b exp 1", req_ready); end
      send(1'b0, 32'hFFFFFFFE, 16'h00F0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp_a = 32'hFFFFFFFE + 32'(i);
         checks++; if ({dc_uop, dc_addr} !== {STR, exp_a}) begin errors++; $display("FAIL wbk_issue[%0d] got %h exp %h", i, {dc_uop, dc_addr}, {STR, exp_a}); end
         checks++; if (dc_data_in !== 32'hD0D00004 + 32'(i)) begin errors++; $display("FAIL wbk_data[%0d] got %h exp %h", i, dc_data_in, 32'hD0D00004 + 32'(i)); end
         cyc();
      end
      checks++; if ({done, base_wb_valid, base_wb_data} !== {2'b11, 32'd2}) begin errors++; $display("FAIL wbk_finish got %h exp %h", {done, base_wb_valid, base_wb_data}, {2'b11, 32'd2}); end
      checks++; if (dc_uop !== NOP) begin errors++; $display("FAIL wbk_finish_uop got %h exp %h", dc_uop, NOP); end
      cyc();
      checks++; if ({done, base_wb_valid, req_ready} !== 3'b001) begin errors++; $display("FAIL wbk_after got %b exp 001", {done, base_wb_valid, req_ready}); end
      send(1'b1, 32'h00001234, 16'h0000, 1'b1);
      checks++; if ({done, base_wb_valid, base_wb_data} !== {2'b11, 32'h00001234}) begin errors++; $display("FAIL empty_finish got %h exp %h", {done, base_wb_valid, base_wb_data}, {2'b11, 32'h00001234}); end
      checks++; if ({dc_uop, wb_valid, req_ready} !== {NOP, 2'b00}) begin errors++; $display("FAIL empty_noaccess got %h exp %h", {dc_uop, wb_valid, req_ready}, {NOP, 2'b00}); end
      cyc();
      checks++; if ({done, req_ready} !== 2'b01) begin errors++; $display("FAIL empty_after got %b exp 01", {done, req_ready}); end
   endtask

   task automatic test_back_to_back();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b exp 1", req_ready); end
      req_valid = 1'b1; req_is_load = 1'b0; req_base = 32'h10; req_reglist = 16'h0003; req_wback = 1'b0;
      cyc();
      req_is_load = 1'b1; req_base = 32'h11; req_reglist = 16'h0002; req_wback = 1'b1;
      checks++; if ({dc_uop, dc_addr, dc_data_in} !== {STR, 32'h10, 32'hAAAA0000}) begin errors++; $display("FAIL b2b_c1 got %h exp %h", {dc_uop, dc_addr, dc_data_in}, {STR, 32'h10, 32'hAAAA0000}); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_c1_ready got %b exp 0", req_ready); end
      cyc();
      checks++; if ({dc_uop, dc_addr, dc_data_in} !== {STR, 32'h11, 32'h11111111}) begin errors++; $display("FAIL b2b_c2 got %h exp %h", {dc_uop, dc_addr, dc_data_in}, {STR, 32'h11, 32'h11111111}); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_c2_ready got %b exp 0", req_ready); end
      cyc();
      checks++; if ({done, req_ready, dc_uop} !== {2'b10, NOP}) begin errors++; $display("FAIL b2b_c3 got %h exp %h", {done, req_ready, dc_uop}, {2'b10, NOP}); end
      cyc();
      checks++; if ({done, req_ready, dc_uop} !== {2'b01, NOP}) begin errors++; $display("FAIL b2b_c4 got %h exp %h", {done, req_ready, dc_uop}, {2'b01, NOP}); end
      cyc();
      req_valid = 1'b0;
      checks++; if ({dc_uop, dc_addr, req_ready} !== {LDR, 32'h11, 1'b0}) begin errors++; $display("FAIL b2b_c5 got %h exp %h", {dc_uop, dc_addr, req_ready}, {LDR, 32'h11, 1'b0}); end
      cyc();
      checks++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 4'd1, 32'h11111111}) begin errors++; $display("FAIL b2b_c6_wb got %h exp %h", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd1, 32'h11111111}); end
      cyc();
      checks++; if ({done, base_wb_valid, base_wb_data} !== {2'b11, 32'h12}) begin errors++; $display("FAIL b2b_c7 got %h exp %h", {done, base_wb_valid, base_wb_data}, {2'b11, 32'h12}); end
      cyc();
   endtask

   task automatic test_reset_midop();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready0 got %b exp 1", req_ready); end
      send(1'b1, 32'd4, 16'h000F, 1'b0);
      checks++; if ({dc_uop, dc_addr} !== {LDR, 32'd4}) begin errors++; $display("FAIL mid_c1 got %h exp %h", {dc_uop, dc_addr}, {LDR, 32'd4}); end
      cyc();
      checks++; if ({dc_uop, dc_addr, wb_valid} !== {LDR, 32'd5, 1'b1}) begin errors++; $display("FAIL mid_c2 got %h exp %h", {dc_uop, dc_addr, wb_valid}, {LDR, 32'd5, 1'b1}); end
      reset = 1'b1;
      cyc();
      checks++; if ({dc_uop, wb_valid, done, req_ready} !== {NOP, 3'b000}) begin errors++; $display("FAIL mid_rst1 got %h exp %h", {dc_uop, wb_valid, done, req_ready}, {NOP, 3'b000}); end
      cyc();
      checks++; if ({dc_uop, wb_valid, done, req_ready} !== {NOP, 3'b000}) begin errors++; $display("FAIL mid_rst2 got %h exp %h", {dc_uop, wb_valid, done, req_ready}, {NOP, 3'b000}); end
      reset = 1'b0;
      cyc();
      checks++; if ({dc_uop, wb_valid, req_ready} !== {NOP, 2'b01}) begin errors++; $display("FAIL mid_post got %h exp %h", {dc_uop, wb_valid, req_ready}, {NOP, 2'b01}); end
      send(1'b1, 32'd5, 16'h0004, 1'b1);
      checks++; if ({dc_uop, dc_addr} !== {LDR, 32'd5}) begin errors++; $display("FAIL mid_new_c1 got %h exp %h", {dc_uop, dc_addr}, {LDR, 32'd5}); end
      cyc();
      checks++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 4'd2, 32'h00002222}) begin errors++; $display("FAIL mid_new_wb got %h exp %h", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd2, 32'h00002222}); end
      cyc();
      checks++; if ({done, base_wb_valid, base_wb_data} !== {2'b11, 32'd6}) begin errors++; $display("FAIL mid_new_done got %h exp %h", {done, base_wb_valid, base_wb_data}, {2'b11, 32'd6}); end
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 16; k++) rf[k] = 32'hD0D00000 + 32'(k);
      rf[0] = 32'hAAAA0000;
      rf[1] = 32'h11111111;
      rf[2] = 32'h00002222;
      for (int k = 0; k < 32; k++) mem[k] = 32'd0;
      mem[6] = 32'h00000066;
      reset = 1'b1; req_valid = 1'b0; req_is_load = 1'b0;
      req_base = 32'd0; req_reglist = 16'd0; req_wback = 1'b0;

      test_reset();
      test_store();
      test_load();
      test_wback_empty();
      test_back_to_back();
      test_reset_midop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
